beat_recorder_bank: RTL

- Multi-slot keystroke recorder/player between the PS/2 key decoder and the buzzer rate dividers.
- Records the live key-code stream as timed events (key, duration in ticks) into one of N_SLOTS slots.
- Each slot replays independently on its own key-code output channel, one buzzer per slot, so several saved recordings can sound at once.
- Successor to the fixed three-switch recording plan: slot count, depth and timing resolution are parametrised, and concurrent playback is added.

---
 rtl/beat_recorder_bank.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/beat_recorder_bank.sv
`default_nettype none
// ============================================================================
// Module   : beat_recorder_bank
// Brief    : Multi-slot timed key-event recorder with concurrent per-slot
//            playback channels. Define BEAT_RECORDER_LOOP_EN for looping replay.
// Revision : 1.0 - initial release
// ============================================================================
module beat_recorder_bank #(
    parameter int N_SLOTS  = 3,
    parameter int SLOT_W   = 2,
    parameter int DEPTH    = 64,
    parameter int KEY_W    = 7,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 500000
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [KEY_W-1:0]           key_in,
    input  logic [SLOT_W-1:0]          slot_sel,
    input  logic                       rec_pulse,
    input  logic                       play_pulse,
    output logic                       rec_active,
    output logic                       rec_full,
    output logic [N_SLOTS-1:0]         slot_valid,
    output logic [N_SLOTS-1:0]         play_active,
    output logic [N_SLOTS*KEY_W-1:0]   play_key
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_evt_w = KEY_W + DUR_W;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TICK_DIV - 1);
    localparam logic [c_ptr_w:0]   c_ptr_last = (c_ptr_w + 1)'(DEPTH - 1);
    localparam logic [DUR_W-1:0]   c_dur_max  = '1;
    localparam logic [DUR_W-1:0]   c_dur_one  = DUR_W'(1);
    localparam logic [SLOT_W:0]    c_n_slots  = (SLOT_W + 1)'(N_SLOTS);

    localparam logic [1:0] REC_IDLE  = 2'd0;
    localparam logic [1:0] REC_RUN   = 2'd1;
    localparam logic [1:0] REC_FLUSH = 2'd2;

    localparam logic [1:0] P_IDLE = 2'd0;
    localparam logic [1:0] P_LOAD = 2'd1;
    localparam logic [1:0] P_HOLD = 2'd2;

    logic [c_cnt_w-1:0] r_tick_cnt;
    logic               w_tick;

    assign w_tick = (r_tick_cnt == c_cnt_last);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    logic [1:0]          r_rec_state;
    logic [SLOT_W-1:0]   r_rec_slot;
    logic [c_ptr_w:0]    r_wr_ptr;
    logic [KEY_W-1:0]    r_cur_key;
    logic [DUR_W-1:0]    r_dur;
    logic                r_rec_full;
    logic [N_SLOTS-1:0]  r_slot_valid;
    logic [c_ptr_w:0]    r_len [N_SLOTS];
    logic [c_evt_w-1:0]  r_mem [N_SLOTS][DEPTH];

    logic                w_rec_start, w_run, w_change, w_sat;
    logic                w_flush_wr, w_evt_wr, w_wr, w_rec_busy;
    logic [c_evt_w-1:0]  w_wr_data;

    assign w_rec_start = (r_rec_state == REC_IDLE) && rec_pulse && ({1'b0, slot_sel} < c_n_slots);
    assign w_run       = (r_rec_state == REC_RUN);
    assign w_rec_busy  = (r_rec_state != REC_IDLE);
    assign w_change    = (key_in != r_cur_key);
    assign w_sat       = (r_dur == c_dur_max);
    // A stop only commits the open event if it carries a key or elapsed time.
    assign w_flush_wr  = w_run && rec_pulse && ((r_dur != '0) || (r_cur_key != '0));
    assign w_evt_wr    = w_run && !rec_pulse && (w_change || w_sat);
    assign w_wr        = w_flush_wr || w_evt_wr;
    assign w_wr_data   = {r_cur_key, (r_dur == '0) ? c_dur_one : r_dur};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rec_state  <= REC_IDLE;
            r_rec_slot   <= '0;
            r_wr_ptr     <= '0;
            r_cur_key    <= '0;
            r_dur        <= '0;
            r_rec_full   <= 1'b0;
            r_slot_valid <= '0;
            for (int s = 0; s < N_SLOTS; s++) r_len[s] <= '0;
        end else begin
            case (r_rec_state)
                REC_IDLE: begin
                    if (w_rec_start) begin
                        r_rec_state            <= REC_RUN;
                        r_rec_slot             <= slot_sel;
                        r_wr_ptr               <= '0;
                        r_len[slot_sel]        <= '0;
                        r_slot_valid[slot_sel] <= 1'b0;
                        r_rec_full             <= 1'b0;
                        r_cur_key              <= key_in;
                        r_dur                  <= '0;
                    end
                end
                REC_RUN: begin
                    if (rec_pulse) begin
                        r_rec_state <= REC_FLUSH;
                        if (w_flush_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
                    end else if (w_evt_wr) begin
                        r_wr_ptr  <= r_wr_ptr + 1'b1;
                        r_cur_key <= key_in;
                        r_dur     <= '0;
                        if (r_wr_ptr == c_ptr_last) begin
                            r_rec_state <= REC_FLUSH;
                            r_rec_full  <= 1'b1;
                        end
                    end else if (w_tick) begin
                        r_dur <= r_dur + 1'b1;
                    end
                end
                REC_FLUSH: begin
                    r_len[r_rec_slot]        <= r_wr_ptr;
                    r_slot_valid[r_rec_slot] <= (r_wr_ptr != '0);
                    r_rec_state              <= REC_IDLE;
                end
                default: r_rec_state <= REC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_rec_slot][r_wr_ptr[c_ptr_w-1:0]] <= w_wr_data;
    end

    assign rec_active = w_rec_busy;
    assign rec_full   = r_rec_full;
    assign slot_valid = r_slot_valid;

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_play
        localparam logic [SLOT_W-1:0] c_id = SLOT_W'(i);

        logic [1:0]         r_state;
        logic [c_ptr_w-1:0] r_rd_ptr;
        logic [DUR_W-1:0]   r_hold;
        logic [KEY_W-1:0]   r_key;
        logic               w_sel, w_abort, w_blocked, w_more;
        logic [c_evt_w-1:0] w_evt;

        assign w_sel     = play_pulse && (slot_sel == c_id);
        // A record start on this slot overrides any playback request or run.
        assign w_abort   = w_rec_start && (slot_sel == c_id);
        assign w_blocked = w_rec_busy && (r_rec_slot == c_id);
        assign w_evt     = r_mem[i][r_rd_ptr];
        assign w_more    = (({1'b0, r_rd_ptr} + 1'b1) < r_len[i]);

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_state  <= P_IDLE;
                r_rd_ptr <= '0;
                r_hold   <= '0;
                r_key    <= '0;
            end else if (w_abort || (w_sel && (r_state != P_IDLE))) begin
                r_state <= P_IDLE;
                r_key   <= '0;
            end else begin
                case (r_state)
                    P_IDLE: begin
                        if (w_sel && r_slot_valid[i] && !w_blocked) begin
                            r_state  <= P_LOAD;
                            r_rd_ptr <= '0;
                        end
                    end
                    P_LOAD: begin
                        r_key   <= w_evt[c_evt_w-1:DUR_W];
                        r_hold  <= w_evt[DUR_W-1:0];
                        r_state <= P_HOLD;
                    end
                    P_HOLD: begin
                        if (w_tick) begin
                            if (r_hold <= c_dur_one) begin
                                if (w_more) begin
                                    r_rd_ptr <= r_rd_ptr + 1'b1;
                                    r_state  <= P_LOAD;
                                end else begin
`ifdef BEAT_RECORDER_LOOP_EN
                                    r_rd_ptr <= '0;
                                    r_state  <= P_LOAD;
`else
                                    r_state  <= P_IDLE;
                                    r_key    <= '0;
`endif
                                end
                            end else begin
                                r_hold <= r_hold - 1'b1;
                            end
                        end
                    end
                    default: r_state <= P_IDLE;
                endcase
            end
        end

        assign play_active[i]               = (r_state == P_LOAD) || (r_state == P_HOLD);
        assign play_key[i*KEY_W +: KEY_W]   = r_key;
    end

endmodule
`default_nettype wire
